gcd_driver: RTL and testbench
=============================

# gcd_driver

Host-side driver for the `gcd` unit's `input_available` / `result_rdy` / `result_taken` handshake. It buffers operand pairs arriving on a valid/ready request channel and issues them to the GCD unit one at a time. It retires each result with `result_taken` and presents results on a valid/ready response channel in issue order. It sits between a testbench or system master and one `gcd` instance, with its ports wired 1:1 to that instance.

## Interface
- `W`, 16: operand and result width; must match the attached `gcd` instance.
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (`reset`=0 resets).
- `req_valid` in 1: upstream operand pair valid.
- `req_ready` out 1: FIFO not full.
- `req_a` in W: operand A.
- `req_b` in W: operand B.
- `rsp_valid` out 1: result register holds an undelivered result.
- `rsp_ready` in 1: downstream accepts result.
- `rsp_data` out W: GCD result.
- `operands_bits_A` out W: to gcd.
- `operands_bits_B` out W: to gcd.
- `input_available` out 1: to gcd.
- `result_bits_data` in W: from gcd.
- `result_rdy` in 1: from gcd.
- `result_taken` out 1: to gcd.
- `busy` out 1: FIFO non-empty, or FSM not in IDLE, or `rsp_valid`.
- `done_count` out 16: results retired from gcd; wraps 0xFFFF→0.

## Operation
- Reset values:
  - `req_ready`=1; `rsp_valid`=0; `rsp_data`=0.
  - `input_available`=0; `result_taken`=0.
  - `operands_bits_A/B`=0; `busy`=0; `done_count`=0; FSM=IDLE; FIFO empty.
- Request push: occurs when `req_valid && req_ready`; {A,B} is written to the FIFO tail.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Push when full is impossible because `req_ready`=0.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO non-empty, pop the head into the op registers (`operands_bits_A/B`) and go to ISSUE. Otherwise stay.
  - ISSUE: `input_available`=1 for exactly this one cycle, with op registers stable. Go to WAIT.
  - WAIT: `input_available`=0. When `result_rdy`=1 and `rsp_valid`=0 (or `rsp_valid && rsp_ready` this cycle):
    - assert `result_taken` (combinational, same cycle);
    - load `result_bits_data` into `rsp_data` and set `rsp_valid`;
    - increment `done_count`;
    - go to IDLE.
  - WAIT, otherwise: hold. `result_taken`=0, and results are never dropped.
- IDLE always lasts ≥1 cycle after a take. This guarantees the gcd has returned to its own idle state before the next `input_available`.
- Op registers hold their value until the next pop; their value is don't-care outside ISSUE/WAIT.
- Response: `rsp_valid` clears on `rsp_valid && rsp_ready` unless it is reloaded in the same cycle.
- Exactly one operation is outstanding at the gcd at any time; ordering is FIFO.
- Operand values are passed unmodified. Zero operands are legal; the result is whatever gcd returns (e.g. (0,7)→7, (9,0)→9).
- Reset asserted mid-operation: all state is cleared immediately, and any queued or in-flight request is discarded. The gcd shares the same reset, so both ends restart together.

## Timing
- Push accepted at edge e0 with FSM in IDLE and FIFO previously empty:
  - pop at e1;
  - `input_available` high during the cycle after e1, i.e. 2 cycles after the push handshake.
- Take-to-next-issue: `result_taken` in cycle c means IDLE in c+1 (pop) and ISSUE in c+2.
- `rsp_valid` rises the cycle after `result_taken`.
- `req_ready` deasserts the cycle after the FIFO reaches DEPTH entries.
- Throughput bound: one operation per (gcd iterations + 4) cycles.

## Structure
- Package `gcd_pkg`:
  - `W` default;
  - FSM state typedef (IDLE, ISSUE, WAIT);
  - `done_count` width constant.
- Sub-module `gcd_req_fifo`: synchronous FIFO, 2W wide, DEPTH deep, pointers with a wrap bit. It provides full, empty, push, and pop with head data; it has no read latency (head is combinational from storage).
- Top level `gcd_driver`: FSM, op registers, response register, counter. The bench instantiates it together with the real `gcd`.

## Test plan
- Reset idle: no stimulus for 20 cycles → `input_available`=0, `result_taken`=0, `rsp_valid`=0, `req_ready`=1, `busy`=0.
- Single op: push (48,18) → `input_available` pulses exactly 1 cycle with A=48, B=18 exactly 2 cycles after push; `rsp_data`=6 with `rsp_valid`; `done_count`=1.
- Back-to-back with ordering: push (48,18), (35,14), (17,5), (0,7) → responses 6, 7, 1, 7 in order; ≥1 IDLE cycle between each `result_taken` and the next `input_available`.
- Response backpressure: `rsp_ready`=0, push (12,8) and (9,6) → first result 4 is held. Second op issues; `result_rdy` stays high with `result_taken`=0 until `rsp_ready`=1; then 4 is delivered, then 3.
- FIFO full: hold `rsp_ready`=0 and push 6 pairs → `req_ready`=0 after DEPTH entries queued (plus ops in flight); no push is lost or duplicated after release.
- Reset mid-operation: assert `reset`=0 during WAIT → all outputs return to reset values asynchronously; after release, (21,6) yields 3 and `done_count`=1.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the gcd host-side driver.
package gcd_pkg;

    // Default operand/result width; must match the attached gcd instance.
    localparam int GCD_W         = 16;

    // Default number of queued operand pairs.
    localparam int GCD_REQ_DEPTH = 4;

    // Width of the retired-result counter (wraps to zero).
    localparam int DONE_CNT_W    = 16;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_req_fifo.sv
// Operand-pair request FIFO: pointers carry a wrap bit so full and empty
// are distinguished without a separate count. Head data is read
// combinationally from storage, so a pop sees the entry in the same cycle.
module gcd_req_fifo
    import gcd_pkg::*;
#(
    parameter int DW    = 2 * GCD_W,
    parameter int DEPTH = GCD_REQ_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push_en;
    logic          pop_en;

    // Gate requests against the flags and advance the pointers.
    always_comb begin
        push_en  = push && !full;
        pop_en   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
    end

    // Pointer registers; cleared by the shared asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/gcd_driver.sv
// Host-side driver for one gcd unit. Queues operand pairs, issues them one
// at a time over the input_available / result_rdy / result_taken handshake,
// and delivers results in issue order on a valid/ready response channel.
module gcd_driver
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W,
    parameter int DEPTH = GCD_REQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [W-1:0]          req_a,
    input  logic [W-1:0]          req_b,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [W-1:0]          rsp_data,
    // gcd unit
    output logic [W-1:0]          operands_bits_A,
    output logic [W-1:0]          operands_bits_B,
    output logic                  input_available,
    input  logic [W-1:0]          result_bits_data,
    input  logic                  result_rdy,
    output logic                  result_taken,
    // status
    output logic                  busy,
    output logic [DONE_CNT_W-1:0] done_count
);

    gcd_state_e            state_q, state_d;
    logic [W-1:0]          op_a_q, op_a_d;
    logic [W-1:0]          op_b_q, op_b_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [W-1:0]          rsp_data_q, rsp_data_d;
    logic [DONE_CNT_W-1:0] done_count_q, done_count_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [2*W-1:0]        fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  issue;
    logic                  take;

    assign fifo_push = req_valid && !fifo_full;

    gcd_req_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({req_a, req_b}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue sequencer: pop into the op registers, pulse input_available for
    // one cycle, then wait until the result can be parked in the response
    // register. Returning to IDLE after every take gives the gcd a cycle to
    // settle back into its own idle state before the next issue.
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        fifo_pop = 1'b0;
        issue    = 1'b0;
        take     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_a_d   = fifo_head[2*W-1:W];
                    op_b_d   = fifo_head[W-1:0];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The response slot is free if empty or draining this cycle.
                if (result_rdy && (!rsp_valid_q || rsp_ready)) begin
                    take    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response register: a take reloads it even while it is being drained.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (take) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = result_bits_data;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Retired-result counter; wraps naturally at its width.
    always_comb begin
        done_count_d = done_count_q;
        if (take) begin
            done_count_d = done_count_q + 1'b1;
        end
    end

    // All driver state clears immediately on reset, discarding any
    // operation in flight; the gcd shares this reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            done_count_q <= done_count_d;
        end
    end

    assign req_ready       = !fifo_full;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign operands_bits_A = op_a_q;
    assign operands_bits_B = op_b_q;
    assign input_available = issue;
    assign result_taken    = take;
    assign done_count      = done_count_q;
    assign busy            = !fifo_empty || (state_q != ST_IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver with a behavioural subtractive gcd unit attached.
module tb_gcd_driver;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] req_a     = '0;
    logic [W-1:0] req_b     = '0;

    logic         req_ready, rsp_valid, input_available, result_rdy, result_taken, busy;
    logic [W-1:0] rsp_data, operands_bits_A, operands_bits_B, result_bits_data;
    logic [15:0]  done_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gcd_driver #(.W(W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .operands_bits_A  (operands_bits_A),
        .operands_bits_B  (operands_bits_B),
        .input_available  (input_available),
        .result_bits_data (result_bits_data),
        .result_rdy       (result_rdy),
        .result_taken     (result_taken),
        .busy             (busy),
        .done_count       (done_count)
    );

    // Behavioural gcd unit: idle -> run (subtract/swap) -> done until taken.
    logic [1:0]   g_st;
    logic [W-1:0] g_x, g_y;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_st <= 2'd0;
            g_x  <= '0;
            g_y  <= '0;
        end else begin
            case (g_st)
                2'd0: if (input_available) begin
                    g_x  <= operands_bits_A;
                    g_y  <= operands_bits_B;
                    g_st <= 2'd1;
                end
                2'd1: begin
                    if (g_y == 0) g_st <= 2'd2;
                    else if (g_x < g_y) begin
                        g_x <= g_y;
                        g_y <= g_x;
                    end else g_x <= g_x - g_y;
                end
                2'd2: if (result_taken) g_st <= 2'd0;
                default: g_st <= 2'd0;
            endcase
        end
    end

    assign result_rdy       = (g_st == 2'd2);
    assign result_bits_data = g_x;

    // Reference gcd (Euclid by remainder).
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Scoreboard and tracking state (all owned by the main initial process).
    logic [W-1:0]   exp_q [$];
    logic [2*W-1:0] iss_q [$];
    int             cyc          = 0;
    int             last_take_cyc = 0;
    int             last_push_cyc = 0;
    int             last_ia_cyc   = -1;
    bit             took      = 0;
    bit             prev_ia   = 0;
    bit             prev_take = 0;
    logic [W-1:0]   prev_res  = '0;
    int             exp_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // One clock: sample at the falling edge, then advance to just past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            if (prev_take) begin
                check("rsp_after_take", rsp_valid, 1);
                check("rsp_data_load", rsp_data, prev_res);
            end
            check("take_rule", result_taken, result_rdy && (!rsp_valid || rsp_ready));
            if (input_available) begin
                check("ia_pulse", prev_ia, 0);
                if (took) check("idle_gap", (cyc - last_take_cyc) >= 2, 1);
                if (iss_q.size() == 0) fail_now("issue_extra");
                else check("issue_ops", {operands_bits_A, operands_bits_B}, iss_q.pop_front());
                last_ia_cyc = cyc;
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(ref_gcd(req_a, req_b));
                iss_q.push_back({req_a, req_b});
                last_push_cyc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) fail_now("rsp_extra");
                else check("rsp_order", rsp_data, exp_q.pop_front());
            end
            prev_ia   = input_available;
            prev_take = result_taken;
            prev_res  = result_bits_data;
            if (result_taken) begin
                took          = 1;
                last_take_cyc = cyc;
            end
        end else begin
            prev_ia   = 0;
            prev_take = 0;
            took      = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        for (int n = 0; n < 1000 && !req_ready; n++) tick();
        check("push_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) tick();
        check("drain", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{16'd48,    16'd18,    16'd6};
        vecs[1] = '{16'd35,    16'd14,    16'd7};
        vecs[2] = '{16'd17,    16'd5,     16'd1};
        vecs[3] = '{16'd0,     16'd7,     16'd7};
        vecs[4] = '{16'd9,     16'd0,     16'd9};
        vecs[5] = '{16'd0,     16'd0,     16'd0};
        vecs[6] = '{16'd65535, 16'd65535, 16'd65535};
        vecs[7] = '{16'd40000, 16'd30000, 16'd10000};
        vecs[8] = '{16'd1,     16'd1,     16'd1};

        // Reset values while held in reset.
        @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_opA", operands_bits_A, 0);
        check("rst_done", done_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle after reset with no stimulus.
        rsp_ready = 1'b1;
        repeat (20) tick();
        check("idle_ia", input_available, 0);
        check("idle_taken", result_taken, 0);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_req_ready", req_ready, 1);
        check("idle_busy", busy, 0);

        // Single operation with issue latency.
        last_ia_cyc = -1;
        push(16'd48, 16'd18);
        for (int n = 0; n < 20 && last_ia_cyc < 0; n++) tick();
        check("ia_latency", last_ia_cyc - last_push_cyc, 2);
        drain();
        exp_done = 1;
        check("single_data", rsp_data, 6);
        check("single_done", done_count, exp_done);
        check("single_rsp_clear", rsp_valid, 0);

        // Table of independent operations.
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].a, vecs[i].b);
            drain();
            exp_done++;
            check("vec_data", rsp_data, vecs[i].exp);
            check("vec_done", done_count, exp_done);
        end

        // Back-to-back with ordering.
        push(16'd48, 16'd18);
        push(16'd35, 16'd14);
        push(16'd17, 16'd5);
        push(16'd0,  16'd7);
        drain();
        exp_done += 4;
        check("b2b_done", done_count, exp_done);

        // Response backpressure: result held, second op waits un-taken.
        rsp_ready = 1'b0;
        push(16'd12, 16'd8);
        push(16'd9,  16'd6);
        for (int n = 0; n < 200 && !rsp_valid; n++) tick();
        check("bp_rsp_valid", rsp_valid, 1);
        for (int n = 0; n < 200 && !result_rdy; n++) tick();
        check("bp_result_rdy", result_rdy, 1);
        repeat (5) tick();
        check("bp_not_taken", result_taken, 0);
        check("bp_held_data", rsp_data, 4);
        check("bp_held_rdy", result_rdy, 1);
        rsp_ready = 1'b1;
        drain();
        exp_done += 2;
        check("bp_done", done_count, exp_done);

        // FIFO full under backpressure.
        rsp_ready = 1'b0;
        push(16'd2,  16'd4);
        push(16'd6,  16'd9);
        push(16'd10, 16'd15);
        push(16'd14, 16'd21);
        push(16'd8,  16'd12);
        push(16'd5,  16'd25);
        for (int n = 0; n < 200 && !result_rdy; n++) tick();
        repeat (3) tick();
        check("full_req_ready", req_ready, 0);
        check("full_busy", busy, 1);
        rsp_ready = 1'b1;
        drain();
        tick();
        exp_done += 6;
        check("full_done", done_count, exp_done);
        check("full_req_ready_after", req_ready, 1);
        check("full_busy_after", busy, 0);

        // Reset in the middle of an operation.
        push(16'd1000, 16'd1);
        repeat (10) tick();
        check("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_ia", input_available, 0);
        check("mid_rst_taken", result_taken, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done_count, 0);
        check("mid_rst_opB", operands_bits_B, 0);
        exp_q.delete();
        iss_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        push(16'd21, 16'd6);
        drain();
        check("post_rst_data", rsp_data, 3);
        check("post_rst_done", done_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
